alu_seq_controller: RTL and testbench

//  Parametrised, sequenced successor to the combinational opcode decoder. Accepts one ALU op per

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_iter_unit.sv | 108 ++++++++++
 rtl/alu_seq_controller.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU controller: opcodes, FSM state
// encoding and the bit-level packer that forms the {remainder, quotient} word.
package alu_pkg;

    // Opcodes (values 11..15 are illegal)
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Widest operand the DIV packer supports (WIDTH must not exceed this)
    localparam int unsigned PACK_MAX_W = 32;

    // Bit idx of the packed DIV word {rem[w-1:0], quo[w-1:0]}. Done one bit at
    // a time so the caller can build an output of exactly 2*w bits without
    // carrying unused high bits around.
    function automatic logic div_pack_bit(
        input logic [PACK_MAX_W-1:0] rem,
        input logic [PACK_MAX_W-1:0] quo,
        input int unsigned           w,
        input int unsigned           idx
    );
        logic bit_v;
        if (idx < w) begin
            bit_v = quo[idx[4:0]];
        end else begin
            bit_v = rem[5'(idx - w)];
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle datapath for MUL (right-shifting shift-add) and DIV (restoring,
// MSB first). Exactly WIDTH iterations after start; done marks the cycle whose
// step values (prod / quo / rem outputs) are the final answer.
module alu_iter_unit import alu_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 start_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quo,
    output logic [WIDTH-1:0]     rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // hi: MUL accumulator / DIV partial remainder
    // lo: MUL multiplier (shifts out, product low half shifts in) / DIV dividend -> quotient
    // opd: multiplicand or divisor
    logic                 busy_q, busy_d;
    logic                 div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     opd_q, opd_d;

    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH-1:0]     mul_hi_s;
    logic [WIDTH-1:0]     mul_lo_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_s;
    logic [WIDTH-1:0]     div_quo_s;
    logic                 done_s;

    // One iteration of each algorithm, evaluated from the current registers
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        mul_hi_s    = mul_sum_s[WIDTH:1];
        mul_lo_s    = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        div_shift_s = {hi_q, lo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opd_q});
        // When the trial subtraction succeeds the difference is below the divisor,
        // so a WIDTH-bit subtraction is exact.
        div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - opd_q) : div_shift_s[WIDTH-1:0];
        div_quo_s   = {lo_q[WIDTH-2:0], div_ge_s};
        done_s      = busy_q && (cnt_q == CNT_LAST);
    end

    // Load on start, otherwise step and count while busy
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opd_d  = opd_q;
        if (start) begin
            busy_d = 1'b1;
            div_d  = start_div;
            cnt_d  = {CNT_W{1'b0}};
            hi_d   = {WIDTH{1'b0}};
            lo_d   = a;
            opd_d  = b;
        end else if (busy_q) begin
            hi_d = div_q ? div_rem_s : mul_hi_s;
            lo_d = div_q ? div_quo_s : mul_lo_s;
            if (done_s) begin
                busy_d = 1'b0;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            opd_q  <= {WIDTH{1'b0}};
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opd_q  <= opd_d;
        end
    end

    assign done = done_s;
    assign prod = {mul_hi_s, mul_lo_s};
    assign quo  = div_quo_s;
    assign rem  = div_rem_s;

endmodule

// File: rtl/alu_seq_controller.sv
// Sequenced ALU: valid/ready op intake, single-cycle logic/add/sub, multi-cycle
// MUL/DIV via alu_iter_unit, result held in DONE until the consumer takes it.
module alu_seq_controller import alu_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry_out,
    output logic                 err
);

    logic [1:0]             state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   carry_q, carry_d;
    logic                   err_q, err_d;

    logic                   accept_s;
    logic [WIDTH:0]         add_s;
    logic [WIDTH:0]         sub_s;
    logic [WIDTH-1:0]       alu_val_s;
    logic                   alu_co_s;
    logic                   iter_start_s;
    logic                   iter_done_s;
    logic [2*WIDTH-1:0]     iter_prod_s;
    logic [WIDTH-1:0]       iter_quo_s;
    logic [WIDTH-1:0]       iter_rem_s;
    logic [WIDTH-1:0]       div_rem_sel_s;
    logic [WIDTH-1:0]       div_quo_sel_s;
    logic [PACK_MAX_W-1:0]  div_rem_ext_s;
    logic [PACK_MAX_W-1:0]  div_quo_ext_s;
    logic [2*WIDTH-1:0]     div_packed_s;

    assign accept_s = in_valid && ready_q;
    // Bit WIDTH of sub_s is the borrow: set exactly when a < b + carry_in
    assign add_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign sub_s    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

    // Single-cycle ops evaluated straight from the inputs at the accept edge
    always_comb begin
        alu_val_s = {WIDTH{1'b0}};
        alu_co_s  = 1'b0;
        case (op)
            OP_AND:  alu_val_s = a & b;
            OP_NAND: alu_val_s = ~(a & b);
            OP_OR:   alu_val_s = a | b;
            OP_NOR:  alu_val_s = ~(a | b);
            OP_XOR:  alu_val_s = a ^ b;
            OP_XNOR: alu_val_s = ~(a ^ b);
            OP_NOT:  alu_val_s = ~a;
            OP_ADD: begin
                alu_val_s = add_s[WIDTH-1:0];
                alu_co_s  = add_s[WIDTH];
            end
            OP_SUB: begin
                alu_val_s = sub_s[WIDTH-1:0];
                alu_co_s  = sub_s[WIDTH];
            end
            default: begin
                alu_val_s = {WIDTH{1'b0}};
                alu_co_s  = 1'b0;
            end
        endcase
    end

    // DIV result source: iteration output while dividing, divide-by-zero pattern otherwise
    always_comb begin
        if (state_q == ST_DIV) begin
            div_rem_sel_s = iter_rem_s;
            div_quo_sel_s = iter_quo_s;
        end else begin
            div_rem_sel_s = a;
            div_quo_sel_s = {WIDTH{1'b1}};
        end
        div_rem_ext_s = PACK_MAX_W'(div_rem_sel_s);
        div_quo_ext_s = PACK_MAX_W'(div_quo_sel_s);
    end

    // Pack {remainder, quotient} into the 2*WIDTH result word
    always_comb begin
        div_packed_s = {(2*WIDTH){1'b0}};
        for (int unsigned i = 0; i < 2*WIDTH; i++) begin
            div_packed_s[i] = div_pack_bit(div_rem_ext_s, div_quo_ext_s, WIDTH, i);
        end
    end

    // Controller FSM and result capture
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        carry_d      = carry_q;
        err_d        = err_q;
        iter_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op <= OP_SUB) begin
                        state_d  = ST_DONE;
                        result_d = {{WIDTH{1'b0}}, alu_val_s};
                        carry_d  = alu_co_s;
                        err_d    = 1'b0;
                    end else if (op == OP_MUL) begin
                        state_d      = ST_MUL;
                        iter_start_s = 1'b1;
                    end else if ((op == OP_DIV) && (b != {WIDTH{1'b0}})) begin
                        state_d      = ST_DIV;
                        iter_start_s = 1'b1;
                    end else if (op == OP_DIV) begin
                        state_d  = ST_DONE;
                        result_d = div_packed_s;
                        carry_d  = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = {(2*WIDTH){1'b0}};
                        carry_d  = 1'b0;
                        err_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (iter_done_s) begin
                    state_d  = ST_DONE;
                    result_d = iter_prod_s;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                if (iter_done_s) begin
                    state_d  = ST_DONE;
                    result_d = div_packed_s;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    // State and registered outputs; handshake flags are never high together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock     (clock),
        .reset     (reset),
        .start     (iter_start_s),
        .start_div (op == OP_DIV),
        .a         (a),
        .b         (b),
        .done      (iter_done_s),
        .prod      (iter_prod_s),
        .quo       (iter_quo_s),
        .rem       (iter_rem_s)
    );

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=8 instance share clock/reset and a
// common stimulus bus; dut_sel picks which one handshakes. Expected values come
// from an arithmetic reference model or from hand-worked constants.
module tb_alu_seq_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        dut_sel;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op_v;
    logic [7:0]  a_v;
    logic [7:0]  b_v;
    logic        cin_v;

    logic        in_valid4, out_ready4, rdy4, ov4, co4, err4;
    logic [7:0]  res4;
    logic        in_valid8, out_ready8, rdy8, ov8, co8, err8;
    logic [15:0] res8;

    logic        rdy_s, ov_s, co_s, err_s;
    logic [15:0] res_s;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign in_valid4  = in_valid  && !dut_sel;
    assign out_ready4 = out_ready && !dut_sel;
    assign in_valid8  = in_valid  &&  dut_sel;
    assign out_ready8 = out_ready &&  dut_sel;
    assign rdy_s = dut_sel ? rdy8 : rdy4;
    assign ov_s  = dut_sel ? ov8  : ov4;
    assign co_s  = dut_sel ? co8  : co4;
    assign err_s = dut_sel ? err8 : err4;
    assign res_s = dut_sel ? res8 : {8'h00, res4};

    alu_seq_controller #(.WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(rdy4),
        .op(op_v), .a(a_v[3:0]), .b(b_v[3:0]), .carry_in(cin_v),
        .out_valid(ov4), .out_ready(out_ready4), .result(res4),
        .carry_out(co4), .err(err4)
    );

    alu_seq_controller #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(rdy8),
        .op(op_v), .a(a_v), .b(b_v), .carry_in(cin_v),
        .out_valid(ov8), .out_ready(out_ready8), .result(res8),
        .carry_out(co8), .err(err8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t sel=%0d)", tag, got, exp, $time, dut_sel);
        end
    endtask

    // Reference: plain arithmetic on unsigned integers, masked to w bits
    task automatic model(input logic [3:0] op_i, input int unsigned ai, input int unsigned bi,
                         input int unsigned ci, input int unsigned w,
                         output logic [15:0] res, output logic co, output logic er, output int lat);
        int unsigned mask;
        int unsigned t;
        mask = (32'd1 << w) - 32'd1;
        t    = 32'd0;
        res  = 16'h0000;
        co   = 1'b0;
        er   = 1'b0;
        lat  = 1;
        case (op_i)
            4'd0: res = 16'(ai & bi);
            4'd1: res = 16'(~(ai & bi) & mask);
            4'd2: res = 16'(ai | bi);
            4'd3: res = 16'(~(ai | bi) & mask);
            4'd4: res = 16'(ai ^ bi);
            4'd5: res = 16'(~(ai ^ bi) & mask);
            4'd6: res = 16'(~ai & mask);
            4'd7: begin
                t   = ai + bi + ci;
                res = 16'(t & mask);
                co  = (t > mask);
            end
            4'd8: begin
                t   = ai - bi - ci;
                res = 16'(t & mask);
                co  = (ai < bi + ci);
            end
            4'd9: begin
                res = 16'(ai * bi);
                lat = int'(w) + 1;
            end
            4'd10: begin
                if (bi == 32'd0) begin
                    res = 16'((ai << w) | mask);
                    er  = 1'b1;
                end else begin
                    res = 16'(((ai % bi) << w) | (ai / bi));
                    lat = int'(w) + 1;
                end
            end
            default: er = 1'b1;
        endcase
    endtask

    task automatic scramble_inputs();
        op_v  = 4'($urandom);
        a_v   = 8'($urandom);
        b_v   = 8'($urandom);
        cin_v = 1'($urandom);
    endtask

    // Issue one op, check latency, busy behaviour, result, hold and release.
    // Called at a point #1 after a rising edge.
    task automatic do_op(input logic [3:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic cin_i, input logic [15:0] exp_res, input logic exp_co,
                         input logic exp_err, input int exp_lat, input int hold);
        int   n;
        int   lat;
        logic busy_bad;
        logic hold_bad;
        n = 0;
        while (!rdy_s && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("ready_wait", 32'(rdy_s), 32'd1);
        in_valid = 1'b1;
        op_v = op_i; a_v = a_i; b_v = b_i; cin_v = cin_i;
        @(posedge clock); #1;
        busy_bad = 1'b0;
        lat      = 1;
        while (!ov_s && lat < 40) begin
            if (rdy_s) busy_bad = 1'b1;
            in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clock); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("busy_ready_low", 32'(busy_bad), 32'd0);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("ready_while_valid", 32'(rdy_s), 32'd0);
        check_eq("result", 32'(res_s), 32'(exp_res));
        check_eq("carry_out", 32'(co_s), 32'(exp_co));
        check_eq("err", 32'(err_s), 32'(exp_err));
        hold_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clock); #1;
            if (!ov_s || rdy_s || res_s !== exp_res || co_s !== exp_co || err_s !== exp_err)
                hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) check_eq("hold_stable", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", 32'(ov_s), 32'd0);
        check_eq("ready_return", 32'(rdy_s), 32'd1);
    endtask

    task automatic rand_op(input int unsigned w);
        logic [3:0]  op_r;
        logic [7:0]  a_r, b_r;
        logic        c_r;
        logic [15:0] er_res;
        logic        er_co, er_err;
        int          er_lat;
        int unsigned mask;
        mask = (32'd1 << w) - 32'd1;
        op_r = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) op_r = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10;
        a_r = 8'($urandom & mask);
        b_r = 8'($urandom & mask);
        if ($urandom_range(0, 7) == 0) b_r = 8'h00;
        c_r = 1'($urandom);
        model(op_r, a_r, b_r, c_r, w, er_res, er_co, er_err, er_lat);
        do_op(op_r, a_r, b_r, c_r, er_res, er_co, er_err, er_lat, $urandom_range(0, 3));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; dut_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_v = 4'd0; a_v = 8'h00; b_v = 8'h00; cin_v = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check_eq("rst_out_valid", 32'(ov_s), 32'd0);
        check_eq("rst_result", 32'(res_s), 32'd0);
        check_eq("rst_carry", 32'(co_s), 32'd0);
        check_eq("rst_err", 32'(err_s), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("rst_ready_after", 32'(rdy_s), 32'd1);
        check_eq("rst_valid_after", 32'(ov_s), 32'd0);

        // Logic sweep, a=1010 b=0101
        do_op(4'd0, 8'hA, 8'h5, 1'b0, 16'h00, 1'b0, 1'b0, 1, 0);
        do_op(4'd1, 8'hA, 8'h5, 1'b0, 16'h0F, 1'b0, 1'b0, 1, 0);
        do_op(4'd2, 8'hA, 8'h5, 1'b0, 16'h0F, 1'b0, 1'b0, 1, 0);
        do_op(4'd3, 8'hA, 8'h5, 1'b0, 16'h00, 1'b0, 1'b0, 1, 0);
        do_op(4'd4, 8'hA, 8'h5, 1'b0, 16'h0F, 1'b0, 1'b0, 1, 0);
        do_op(4'd5, 8'hA, 8'h5, 1'b0, 16'h00, 1'b0, 1'b0, 1, 0);
        do_op(4'd6, 8'hA, 8'h5, 1'b0, 16'h05, 1'b0, 1'b0, 1, 0);
        // Add/sub, carry and borrow
        do_op(4'd7, 8'h3, 8'h1, 1'b0, 16'h04, 1'b0, 1'b0, 1, 0);
        do_op(4'd7, 8'hF, 8'h1, 1'b0, 16'h00, 1'b1, 1'b0, 1, 1);
        do_op(4'd8, 8'h4, 8'h2, 1'b0, 16'h02, 1'b0, 1'b0, 1, 0);
        do_op(4'd8, 8'h0, 8'h1, 1'b0, 16'h0F, 1'b1, 1'b0, 1, 0);
        do_op(4'd8, 8'h5, 8'h4, 1'b1, 16'h00, 1'b0, 1'b0, 1, 0);
        // MUL with long backpressure; inputs scrambled while busy
        do_op(4'd9, 8'h3, 8'h2, 1'b0, 16'h06, 1'b0, 1'b0, 5, 10);
        do_op(4'd9, 8'hF, 8'hF, 1'b0, 16'hE1, 1'b0, 1'b0, 5, 0);
        // DIV, divide-by-zero, illegal op
        do_op(4'd10, 8'h4, 8'h2, 1'b0, 16'h02, 1'b0, 1'b0, 5, 0);
        do_op(4'd10, 8'h7, 8'h2, 1'b0, 16'h13, 1'b0, 1'b0, 5, 2);
        do_op(4'd10, 8'h6, 8'h0, 1'b0, 16'h6F, 1'b0, 1'b1, 1, 0);

        // Reset in the middle of a DIV, previous result 0x6F still on the outputs
        in_valid = 1'b1; op_v = 4'd10; a_v = 8'h7; b_v = 8'h2; cin_v = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(ov_s), 32'd0);
        check_eq("midrst_result", 32'(res_s), 32'd0);
        check_eq("midrst_err", 32'(err_s), 32'd0);
        check_eq("midrst_carry", 32'(co_s), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("midrst_ready_after", 32'(rdy_s), 32'd1);
        check_eq("midrst_no_valid", 32'(ov_s), 32'd0);
        do_op(4'd10, 8'h7, 8'h2, 1'b0, 16'h13, 1'b0, 1'b0, 5, 0);
        do_op(4'd13, 8'h9, 8'h3, 1'b1, 16'h00, 1'b0, 1'b1, 1, 1);

        for (int k = 0; k < 60; k++) rand_op(4);

        // WIDTH=8 instance
        dut_sel = 1'b1;
        do_op(4'd9, 8'd200, 8'd255, 1'b0, 16'd51000, 1'b0, 1'b0, 9, 0);
        do_op(4'd10, 8'd200, 8'd7, 1'b0, 16'h041C, 1'b0, 1'b0, 9, 3);
        do_op(4'd10, 8'd7, 8'd2, 1'b0, 16'h0103, 1'b0, 1'b0, 9, 0);
        do_op(4'd10, 8'd9, 8'd0, 1'b0, 16'h09FF, 1'b0, 1'b1, 1, 0);
        do_op(4'd7, 8'hFF, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0, 1, 0);
        for (int k = 0; k < 60; k++) rand_op(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
